// File: rtl/phase_acc_gen_pkg.sv
//------------------------------------------------------------------------------
// Module : phase_acc_gen_pkg
// Brief  : Shared constants and sweep FSM state encoding for phase_acc_gen.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package phase_acc_gen_pkg;

    // Phase width shared with the waveGen DDS phase input
    localparam int c_PHASE_W_DEFAULT = 10;
    localparam int c_ACC_W_DEFAULT   = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_SWEEP = 2'd2
    } state_t;

endpackage : phase_acc_gen_pkg

`default_nettype wire

// File: rtl/phase_acc_gen_core.sv
//------------------------------------------------------------------------------
// Module : phase_acc_core
// Brief  : Phase accumulator with carry-out wrap flag and registered offset add.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module phase_acc_core #(
    parameter int ACC_W   = 24,
    parameter int PHASE_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               sync_clr,
    input  logic [ACC_W-1:0]   ftw,
    input  logic [PHASE_W-1:0] poff,
    output logic [PHASE_W-1:0] phase,
    output logic               phase_valid,
    output logic               wrap
);

    logic [ACC_W-1:0]   r_acc;
    logic [PHASE_W-1:0] r_phase;
    logic               r_valid;
    logic               r_wrap;
    logic [ACC_W:0]     w_sum;
    logic [PHASE_W-1:0] w_phase_next;

    // One extra bit so the carry out of the accumulator becomes the wrap flag
    assign w_sum        = {1'b0, r_acc} + {1'b0, ftw};
    assign w_phase_next = w_sum[ACC_W-1 -: PHASE_W] + poff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_phase <= '0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (sync_clr) begin
            r_acc   <= '0;
            r_phase <= poff;
            r_valid <= en;
            r_wrap  <= 1'b0;
        end else if (en) begin
            r_acc   <= w_sum[ACC_W-1:0];
            r_phase <= w_phase_next;
            r_valid <= 1'b1;
            r_wrap  <= w_sum[ACC_W];
        end else begin
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
        end
    end

    assign phase       = r_phase;
    assign phase_valid = r_valid;
    assign wrap        = r_wrap;

endmodule : phase_acc_core

`default_nettype wire

// File: rtl/phase_acc_gen.sv
//------------------------------------------------------------------------------
// Module : phase_acc_gen
// Brief  : NCO phase source with FTW/offset registers and linear FTW sweep.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module phase_acc_gen
    import phase_acc_gen_pkg::*;
#(
    parameter int ACC_W   = c_ACC_W_DEFAULT,
    parameter int PHASE_W = c_PHASE_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               sync_clr,
    input  logic [ACC_W-1:0]   ftw_in,
    input  logic               ftw_load,
    input  logic [PHASE_W-1:0] poff_in,
    input  logic               poff_load,
    input  logic               sweep_start,
    input  logic [ACC_W-1:0]   sweep_step,
    input  logic [ACC_W-1:0]   sweep_limit,
    output logic [PHASE_W-1:0] phase,
    output logic               phase_valid,
    output logic               wrap,
    output logic               sweep_done,
    output logic               busy
);

    state_t             r_state;
    state_t             w_state_next;
    logic [ACC_W-1:0]   r_ftw;
    logic [ACC_W-1:0]   w_ftw_next;
    logic [PHASE_W-1:0] r_poff;
    logic               r_done;
    logic               w_done_next;
    logic [ACC_W:0]     w_sweep_sum;
    logic               w_sweep_hit;
    logic               w_start_clamp;

    // Overflow of the ACC_W+1 bit sum always exceeds any ACC_W limit
    assign w_sweep_sum   = {1'b0, r_ftw} + {1'b0, sweep_step};
    assign w_sweep_hit   = (w_sweep_sum >= {1'b0, sweep_limit});
    assign w_start_clamp = (sweep_step == '0) || (r_ftw >= sweep_limit);

    always_comb begin
        w_state_next = r_state;
        w_ftw_next   = r_ftw;
        w_done_next  = 1'b0;
        case (r_state)
            ST_IDLE, ST_RUN: begin
                if (sweep_start) begin
                    if (w_start_clamp) begin
                        w_ftw_next   = sweep_limit;
                        w_done_next  = 1'b1;
                        w_state_next = ST_RUN;
                    end else begin
                        w_state_next = ST_SWEEP;
                        if (ftw_load) begin
                            w_ftw_next = ftw_in;
                        end
                    end
                end else begin
                    if (ftw_load) begin
                        w_ftw_next = ftw_in;
                    end
                    if (r_state == ST_IDLE && en) begin
                        w_state_next = ST_RUN;
                    end else if (r_state == ST_RUN && !en) begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            ST_SWEEP: begin
                if (en) begin
                    if (w_sweep_hit) begin
                        w_ftw_next   = sweep_limit;
                        w_done_next  = 1'b1;
                        w_state_next = ST_RUN;
                    end else begin
                        w_ftw_next = w_sweep_sum[ACC_W-1:0];
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ftw   <= '0;
            r_poff  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ftw   <= w_ftw_next;
            r_done  <= w_done_next;
            if (poff_load) begin
                r_poff <= poff_in;
            end
        end
    end

    phase_acc_core #(
        .ACC_W   (ACC_W),
        .PHASE_W (PHASE_W)
    ) u_core (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .sync_clr    (sync_clr),
        .ftw         (r_ftw),
        .poff        (r_poff),
        .phase       (phase),
        .phase_valid (phase_valid),
        .wrap        (wrap)
    );

    assign sweep_done = r_done;
    assign busy       = (r_state == ST_SWEEP);

endmodule : phase_acc_gen

`default_nettype wire

// File: tb/tb_phase_acc_gen.sv
//------------------------------------------------------------------------------
// Module : tb_phase_acc_gen
// Brief  : Self-checking bench for phase_acc_gen against an arithmetic model.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_phase_acc_gen;

    localparam int     ACC_W   = 24;
    localparam int     PHASE_W = 10;
    localparam longint MOD     = 64'd1 << ACC_W;
    localparam longint PMOD    = 64'd1 << PHASE_W;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic               sync_clr;
    logic [ACC_W-1:0]   ftw_in;
    logic               ftw_load;
    logic [PHASE_W-1:0] poff_in;
    logic               poff_load;
    logic               sweep_start;
    logic [ACC_W-1:0]   sweep_step;
    logic [ACC_W-1:0]   sweep_limit;
    logic [PHASE_W-1:0] phase;
    logic               phase_valid;
    logic               wrap;
    logic               sweep_done;
    logic               busy;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    longint m_acc, m_ftw, m_poff, m_phase;
    bit     m_valid, m_wrap, m_done, m_busy;

    phase_acc_gen #(
        .ACC_W   (ACC_W),
        .PHASE_W (PHASE_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .sync_clr    (sync_clr),
        .ftw_in      (ftw_in),
        .ftw_load    (ftw_load),
        .poff_in     (poff_in),
        .poff_load   (poff_load),
        .sweep_start (sweep_start),
        .sweep_step  (sweep_step),
        .sweep_limit (sweep_limit),
        .phase       (phase),
        .phase_valid (phase_valid),
        .wrap        (wrap),
        .sweep_done  (sweep_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_ftw = 0; m_poff = 0; m_phase = 0;
        m_valid = 0; m_wrap = 0; m_done = 0; m_busy = 0;
    endtask

    // Behavioural view: registers as plain integers, updated once per edge
    task automatic model_edge();
        longint sum;
        longint n_ftw;
        bit     n_busy;
        bit     n_done;
        if (rst) begin
            model_reset();
            return;
        end
        n_ftw = m_ftw; n_busy = m_busy; n_done = 0;
        if (m_busy) begin
            if (en) begin
                sum = m_ftw + longint'(sweep_step);
                if (sum >= longint'(sweep_limit)) begin
                    n_ftw = sweep_limit; n_done = 1; n_busy = 0;
                end else begin
                    n_ftw = sum;
                end
            end
        end else if (sweep_start) begin
            if (sweep_step == 0 || m_ftw >= longint'(sweep_limit)) begin
                n_ftw = sweep_limit; n_done = 1;
            end else begin
                n_busy = 1;
                if (ftw_load) n_ftw = ftw_in;
            end
        end else if (ftw_load) begin
            n_ftw = ftw_in;
        end

        if (sync_clr) begin
            m_acc = 0; m_phase = m_poff; m_valid = en; m_wrap = 0;
        end else if (en) begin
            sum     = m_acc + m_ftw;
            m_wrap  = (sum >= MOD);
            m_acc   = sum % MOD;
            m_phase = (m_acc / (MOD / PMOD) + m_poff) % PMOD;
            m_valid = 1;
        end else begin
            m_valid = 0; m_wrap = 0;
        end
        if (poff_load) m_poff = poff_in;
        m_ftw = n_ftw; m_busy = n_busy; m_done = n_done;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("phase",       phase,       m_phase);
            check("phase_valid", phase_valid, m_valid);
            check("wrap",        wrap,        m_wrap);
            check("sweep_done",  sweep_done,  m_done);
            check("busy",        busy,        m_busy);
        end
    end

    initial begin
        rst = 1; en = 0; sync_clr = 0; ftw_in = 0; ftw_load = 0;
        poff_in = 0; poff_load = 0; sweep_start = 0; sweep_step = 0; sweep_limit = 0;
        model_reset();
        tick(); tick();
        chk_en = 1;
        check("rst_phase", phase, 0);
        check("rst_busy", busy, 0);
        rst = 0;

        // Ramp at FTW 0x100000: 64 per update, wrap on the 16th
        ftw_in = 24'h100000; ftw_load = 1; tick(); ftw_load = 0;
        en = 1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check("ramp_phase", phase, (i * 64) % 1024);
            check("ramp_wrap", wrap, longint'(i == 16));
        end
        for (int i = 0; i < 5; i++) tick();
        check("pre_ftw_phase", phase, 320);

        // FTW change keeps phase continuous
        en = 0; ftw_in = 24'h200000; ftw_load = 1; tick(); ftw_load = 0;
        en = 1; tick(); check("ftw_chg_1", phase, 448);
        tick(); check("ftw_chg_2", phase, 576);

        // Offset step then sync clear
        en = 0; sync_clr = 1; ftw_in = 24'h100000; ftw_load = 1; tick();
        sync_clr = 0; ftw_load = 0;
        en = 1; tick(); check("poff_base", phase, 64);
        en = 0; poff_in = 10'h200; poff_load = 1; tick(); poff_load = 0;
        en = 1; tick(); check("poff_step", phase, 640);
        sync_clr = 1; tick(); sync_clr = 0;
        check("sync_clr_phase", phase, 512);
        check("sync_clr_valid", phase_valid, 1);
        tick(); check("post_clr", phase, 576);

        // Hold with en low
        en = 0; sync_clr = 1; poff_in = 0; poff_load = 1; tick();
        sync_clr = 0; poff_load = 0;
        en = 1; for (int i = 0; i < 4; i++) tick();
        en = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_phase", phase, 256);
            check("hold_valid", phase_valid, 0);
            check("hold_wrap", wrap, 0);
        end
        en = 1; tick(); check("resume", phase, 320);

        // Sweep 0x010000 -> 0x018000 -> clamp 0x020000
        en = 0; ftw_in = 24'h010000; ftw_load = 1; tick(); ftw_load = 0;
        sweep_step = 24'h008000; sweep_limit = 24'h020000; sweep_start = 1; tick();
        sweep_start = 0;
        check("sweep_busy0", busy, 1);
        en = 1; tick();
        check("sweep_ph1", phase, 324); check("sweep_busy1", busy, 1); check("sweep_done1", sweep_done, 0);
        tick();
        check("sweep_ph2", phase, 330); check("sweep_busy2", busy, 0); check("sweep_done2", sweep_done, 1);
        tick();
        check("sweep_ph3", phase, 338); check("sweep_done3", sweep_done, 0);

        // Asynchronous reset mid-sweep
        en = 0; ftw_in = 24'h001000; ftw_load = 1; tick(); ftw_load = 0;
        sweep_step = 24'h000100; sweep_limit = 24'hF00000; sweep_start = 1; tick(); sweep_start = 0;
        en = 1; tick(); tick(); tick();
        check("mid_sweep_busy", busy, 1);
        #3 rst = 1; model_reset();
        #1;
        check("arst_phase", phase, 0); check("arst_busy", busy, 0);
        check("arst_valid", phase_valid, 0); check("arst_done", sweep_done, 0);
        tick();
        rst = 0; en = 0; tick();
        check("post_rst_done", sweep_done, 0);

        // Zero step: immediate clamp to the limit
        ftw_in = 24'h001234; ftw_load = 1; tick(); ftw_load = 0;
        sweep_step = 0; sweep_limit = 24'h005000; sweep_start = 1; tick(); sweep_start = 0;
        check("zstep_done", sweep_done, 1); check("zstep_busy", busy, 0);
        tick(); check("zstep_done_clr", sweep_done, 0);
        en = 1; tick(); check("zstep_ftw", phase, 1);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            en          = ($urandom_range(0, 9) < 8);
            sync_clr    = ($urandom_range(0, 39) == 0);
            ftw_load    = ($urandom_range(0, 9) == 0);
            ftw_in      = 24'($urandom);
            poff_load   = ($urandom_range(0, 9) == 0);
            poff_in     = 10'($urandom);
            sweep_start = ($urandom_range(0, 19) == 0);
            sweep_step  = ($urandom_range(0, 3) == 0) ? 24'd0 : 24'($urandom_range(1, 24'h080000));
            sweep_limit = 24'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1; model_reset();
                tick();
                rst = 0;
            end else begin
                tick();
            end
        end

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_phase_acc_gen

`default_nettype wire
